// File: rtl/c_ext_pkg.sv
// Shared compressed-extension definitions: align-state encoding,
// the compressed-halfword test and the canonical NOP.
package c_ext_pkg;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HALF    = 2'd1,
        SKIP    = 2'd2
    } align_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic is_comp(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_align.sv
// Fetch realigner: splits word-aligned prefetch data into 16/32-bit
// instructions, holding a dangling upper halfword across words.
module if_align
    import c_ext_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pref_valid_i,
    input  logic [31:0] pref_data_i,
    output logic        pref_ready_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        is_comp_o
);

    align_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  held_q, held_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         comp_q, comp_d;
    logic         take;
    logic         advance;
    logic [15:0]  lo, hi;
    logic         unused_pc0;

    assign lo         = pref_data_i[15:0];
    assign hi         = pref_data_i[31:16];
    assign advance    = !valid_q || id_ready_i;
    assign unused_pc0 = redirect_pc_i[0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        held_d  = held_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        comp_d  = comp_q;
        take    = 1'b0;
        if (redirect_i) begin
            valid_d = 1'b0;
            held_d  = 16'h0;
            pc_d    = {redirect_pc_i[31:1], 1'b0};
            state_d = redirect_pc_i[1] ? SKIP : ALIGNED;
        end else if (advance) begin
            valid_d = 1'b0;
            unique case (state_q)
                ALIGNED: begin
                    if (pref_valid_i) begin
                        take    = 1'b1;
                        valid_d = 1'b1;
                        ipc_d   = pc_q;
                        if (is_comp(lo)) begin
                            instr_d = {16'h0, lo};
                            comp_d  = 1'b1;
                            held_d  = hi;
                            state_d = HALF;
                            pc_d    = pc_q + 32'd2;
                        end else begin
                            instr_d = pref_data_i;
                            comp_d  = 1'b0;
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                end
                HALF: begin
                    // A compressed held half needs no new word.
                    if (is_comp(held_q)) begin
                        valid_d = 1'b1;
                        ipc_d   = pc_q;
                        instr_d = {16'h0, held_q};
                        comp_d  = 1'b1;
                        state_d = ALIGNED;
                        pc_d    = pc_q + 32'd2;
                    end else if (pref_valid_i) begin
                        take    = 1'b1;
                        valid_d = 1'b1;
                        ipc_d   = pc_q;
                        instr_d = {lo, held_q};
                        comp_d  = 1'b0;
                        held_d  = hi;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                SKIP: begin
                    if (pref_valid_i) begin
                        take    = 1'b1;
                        held_d  = hi;
                        state_d = HALF;
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ALIGNED;
            pc_q    <= RESET_PC;
            held_q  <= 16'h0;
            valid_q <= 1'b0;
            instr_q <= NOP;
            ipc_q   <= RESET_PC;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            comp_q  <= comp_d;
        end
    end

    assign pref_ready_o  = take && !reset;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign is_comp_o     = comp_q;

endmodule

// File: tb/tb_if_align.sv
// Directed bench for if_align: reset, alignment cases, stall,
// redirect, PC wrap and reset mid-instruction.
module tb_if_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        pref_valid_i;
    logic [31:0] pref_data_i;
    logic        pref_ready_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        is_comp_o;

    int n_chk = 0;
    int n_fail = 0;

    if_align dut (
        .clk          (clk),
        .reset        (reset),
        .pref_valid_i (pref_valid_i),
        .pref_data_i  (pref_data_i),
        .pref_ready_o (pref_ready_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_ready_i   (id_ready_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .is_comp_o    (is_comp_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        pref_valid_i = 1'b1; pref_data_i = 32'h0010_0093; id_ready_i = 1'b1;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b want 0", pref_ready_o);
        end
        tick; tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b0, 32'h0000_0013, 32'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        reset = 1'b0; redirect_i = 1'b0; pref_valid_i = 1'b0;
    endtask

    task automatic test_aligned32;
        pref_valid_i = 1'b1; pref_data_i = 32'h0010_0093;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL a32_ready got %b want 1", pref_ready_o);
        end
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL a32_first got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        pref_data_i = 32'h0000_0013;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b1, 32'h0000_0013, 32'h8000_0004}) begin
            n_fail++;
            $display("FAIL a32_second got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
        pref_valid_i = 1'b0;
        tick;
        n_chk++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL a32_absent got %b want 0", instr_valid_o);
        end
    endtask

    task automatic test_comp_pair;
        pref_valid_i = 1'b1; pref_data_i = 32'h4505_4501;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0000_4501, 32'h8000_0008, 1'b1}) begin
            n_fail++;
            $display("FAIL pair_lo got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        pref_data_i = 32'h0010_0093;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL pair_noconsume got %b want 0", pref_ready_o);
        end
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0000_4505, 32'h8000_000A, 1'b1}) begin
            n_fail++;
            $display("FAIL pair_hi got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0010_0093, 32'h8000_000C, 1'b0}) begin
            n_fail++;
            $display("FAIL pair_next got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
    endtask

    task automatic test_spanning;
        pref_data_i = 32'h0093_4501;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0000_4501, 32'h8000_0010, 1'b1}) begin
            n_fail++;
            $display("FAIL span_lo got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        pref_data_i = 32'hABCD_0010;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL span_ready got %b want 1", pref_ready_o);
        end
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0010_0093, 32'h8000_0012, 1'b0}) begin
            n_fail++;
            $display("FAIL span_word got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        pref_valid_i = 1'b0;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0000_ABCD, 32'h8000_0016, 1'b1}) begin
            n_fail++;
            $display("FAIL span_held got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
    endtask

    task automatic test_stall;
        pref_valid_i = 1'b1; pref_data_i = 32'h1234_5037;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b1, 32'h1234_5037, 32'h8000_0018}) begin
            n_fail++;
            $display("FAIL stall_pre got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
        id_ready_i = 1'b0; pref_data_i = 32'h0050_0113;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (pref_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, pref_ready_o);
            end
            tick;
            n_chk++;
            if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
                {1'b1, 32'h1234_5037, 32'h8000_0018, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%h", i,
                         instr_valid_o, instr_o, instr_pc_o);
            end
        end
        id_ready_i = 1'b1;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b1, 32'h0050_0113, 32'h8000_001C}) begin
            n_fail++;
            $display("FAIL stall_release got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
    endtask

    task automatic test_redirect;
        id_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL redir_ready got %b want 0", pref_ready_o);
        end
        tick;
        n_chk++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL redir_flush got %b want 0", instr_valid_o);
        end
        redirect_i = 1'b0; id_ready_i = 1'b1; pref_data_i = 32'h4505_FFFF;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL skip_ready got %b want 1", pref_ready_o);
        end
        tick;
        n_chk++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL skip_noemit got %b want 0", instr_valid_o);
        end
        pref_valid_i = 1'b0;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0000_4505, 32'h0000_0102, 1'b1}) begin
            n_fail++;
            $display("FAIL skip_hi got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
    endtask

    task automatic test_wrap;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick;
        redirect_i = 1'b0; pref_valid_i = 1'b1; pref_data_i = 32'h4505_4501;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b1, 32'h0000_4501, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_a got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
        pref_data_i = 32'h0010_0093;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b1, 32'h0000_4505, 32'hFFFF_FFFE}) begin
            n_fail++;
            $display("FAIL wrap_b got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b1, 32'h0010_0093, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL wrap_c got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
    endtask

    task automatic test_reset_mid;
        pref_data_i = 32'h0093_4501;
        tick;
        reset = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0202;
        pref_data_i = 32'hABCD_0010;
        #1;
        n_chk++;
        if (pref_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ready got %b want 0", pref_ready_o);
        end
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !==
            {1'b0, 32'h0000_0013, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL rmid_state got v=%b i=%h pc=%h", instr_valid_o,
                     instr_o, instr_pc_o);
        end
        reset = 1'b0; redirect_i = 1'b0; pref_data_i = 32'h0010_0093;
        tick;
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o, is_comp_o} !==
            {1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_after got v=%b i=%h pc=%h c=%b", instr_valid_o,
                     instr_o, instr_pc_o, is_comp_o);
        end
        pref_valid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pref_valid_i = 1'b0; pref_data_i = 32'h0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b1;
        tick;
        test_reset;
        test_aligned32;
        test_comp_pair;
        test_spanning;
        test_stall;
        test_redirect;
        test_wrap;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
